bus_arbiter: RTL and testbench

- Grants ownership of the shared single-wire serial `bus` to one node at a time, among up to 16 nodes (4-bit node address).
- Round-robin fair; the owner holds the bus until it drops its request.
- Enforces an inter-frame idle gap and a watchdog hold limit, so a stuck node cannot monopolise the bus.
- Sits beside the nodes: each node raises `req` before driving `bus` and transmits only while its `grant` bit is high.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 24 ++
 rtl/bus_arbiter.sv | 99 +++++++++
 tb/tb_bus_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, size defaults and helpers for the bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam int N_NODES_DEF = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int MAX_NODES   = 64;

    function automatic logic [MAX_NODES-1:0] onehot(input int unsigned idx);
        return MAX_NODES'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant signals shared between the nodes and the arbiter
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
);
    logic [N_NODES-1:0] req;
    logic [N_NODES-1:0] node_en;
    logic [N_NODES-1:0] grant;
    logic               grant_valid;
    logic [ADDR_W-1:0]  grant_addr;
    logic               bus_busy;
    logic               timeout;

    modport master (
        output req, node_en,
        input  grant, grant_valid, grant_addr, bus_busy, timeout
    );

    modport slave (
        input  req, node_en,
        output grant, grant_valid, grant_addr, bus_busy, timeout
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set request at or after ptr wins
module rr_pick #(
    parameter int N_NODES = 16,
    parameter int ADDR_W  = 4
) (
    input  logic [N_NODES-1:0] qreq,
    input  logic [ADDR_W-1:0]  ptr,
    output logic [ADDR_W-1:0]  winner,
    output logic               any
);
    logic [2*N_NODES-1:0] dbl;
    logic [N_NODES-1:0]   rot;

    assign dbl = {qreq, qreq} >> ptr;
    assign rot = dbl[N_NODES-1:0];
    assign any = |qreq;

    // scan from the far end so the lowest rotated offset is the last to write
    always_comb begin
        winner = '0;
        for (int i = N_NODES - 1; i >= 0; i--)
            if (rot[i]) winner = ADDR_W'((int'(ptr) + i) % N_NODES);
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared serial bus with idle gap and hold watchdog
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_NODES    = N_NODES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_HOLD   = 128
) (
    input logic          clock,
    input logic          reset_n,
    bus_arbiter_if.slave arb
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N_NODES - 1);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  ptr, ptr_n, grant_addr, addr_n, winner;
    logic [N_NODES-1:0] grant, grant_n, qreq;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               timeout, timeout_n, any, owner_req, expired;

    assign qreq      = arb.req & arb.node_en;
    assign owner_req = |(qreq & grant);
    assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);

    rr_pick #(.N_NODES(N_NODES), .ADDR_W(ADDR_W)) u_pick (
        .qreq   (qreq),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // next-state and next-output decode; a release beats the watchdog so no pulse on a tie
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        grant_n   = grant;
        addr_n    = grant_addr;
        hold_n    = hold_cnt;
        gap_n     = gap_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: if (any) begin
                grant_n = N_NODES'(onehot(int'(winner)));
                addr_n  = winner;
                hold_n  = HOLD_W'(1);
                ptr_n   = (winner == LAST) ? '0 : winner + 1'b1;
                state_n = GRANT;
            end
            GRANT: if (!owner_req || expired) begin
                grant_n   = '0;
                addr_n    = '0;
                hold_n    = '0;
                gap_n     = GAP_INIT;
                timeout_n = owner_req;
                state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
                hold_n = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
            end
            GAP: begin
                gap_n   = gap_cnt - 1'b1;
                state_n = (gap_cnt == GAP_W'(1)) ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, pointer, counters and output registers; async reset drops the grant at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            grant_addr <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            grant      <= grant_n;
            grant_addr <= addr_n;
            hold_cnt   <= hold_n;
            gap_cnt    <= gap_n;
            timeout    <= timeout_n;
        end
    end

    assign arb.grant       = grant;
    assign arb.grant_valid = |grant;
    assign arb.grant_addr  = grant_addr;
    assign arb.bus_busy    = (state == GRANT) || (state == GAP);
    assign arb.timeout     = timeout;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of round-robin grant, gap, watchdog, enable and reset behaviour
module tb_bus_arbiter;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter_if #(.N_NODES(16), .ADDR_W(4)) arb ();

    bus_arbiter #(.N_NODES(16), .ADDR_W(4), .GAP_CYCLES(2), .MAX_HOLD(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .arb     (arb)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_out(input string tag);
        check({tag, "_grant"}, 32'(arb.grant), 0);
        check({tag, "_valid"}, 32'(arb.grant_valid), 0);
        check({tag, "_addr"}, 32'(arb.grant_addr), 0);
        check({tag, "_busy"}, 32'(arb.bus_busy), 0);
        check({tag, "_timeout"}, 32'(arb.timeout), 0);
    endtask

    task automatic owned(input string tag, input int node);
        check({tag, "_grant"}, 32'(arb.grant), 32'(1) << node);
        check({tag, "_addr"}, 32'(arb.grant_addr), 32'(node));
        check({tag, "_valid"}, 32'(arb.grant_valid), 1);
        check({tag, "_busy"}, 32'(arb.bus_busy), 1);
    endtask

    // owner holds 5 cycles, drops for one edge, re-requests; next grant lands 3 edges later
    task automatic frame(input int node, input int next, input logic [15:0] base);
        owned("rr_own", node);
        repeat (4) tick();
        arb.req = base & ~(16'(1) << node);
        tick();
        check("rr_rel", 32'(arb.grant_valid), 0);
        check("rr_no_to", 32'(arb.timeout), 0);
        arb.req = base;
        tick();
        check("rr_gap1", 32'(arb.grant_valid), 0);
        tick();
        check("rr_gap2", 32'(arb.grant_valid), 0);
        tick();
        owned("rr_next", next);
    endtask

    task automatic drain();
        arb.req = '0;
        repeat (4) tick();
        check("drain_busy", 32'(arb.bus_busy), 0);
    endtask

    initial begin
        arb.req     = '0;
        arb.node_en = 16'hFFFF;
        #1 reset_n = 1'b0;
        #1 idle_out("reset");
        tick();
        reset_n = 1'b1;
        tick();
        idle_out("idle");

        // single requester: 1-cycle latency, then exactly 2 busy gap cycles
        arb.req = 16'h0002;
        tick();
        owned("single", 1);
        arb.req = '0;
        tick();
        check("single_drop", 32'(arb.grant), 0);
        check("single_gap_a", 32'(arb.bus_busy), 1);
        tick();
        check("single_gap_b", 32'(arb.bus_busy), 1);
        tick();
        check("single_idle", 32'(arb.bus_busy), 0);

        // contention on nodes 0 and 2, ptr starts at 2
        arb.req = 16'h0005;
        tick();
        frame(2, 0, 16'h0005);
        frame(0, 2, 16'h0005);
        frame(2, 0, 16'h0005);
        frame(0, 2, 16'h0005);
        drain();

        // wrap-around: node 14 leaves ptr at 15
        arb.req = 16'h4000;
        tick();
        owned("wrap14", 14);
        arb.req = 16'h8001;
        repeat (4) tick();
        owned("wrap15", 15);
        arb.req = 16'h0001;
        repeat (4) tick();
        owned("wrap0", 0);
        drain();

        // watchdog: node 3 stuck for 8 cycles, node 4 waiting
        arb.req = 16'h0018;
        tick();
        owned("wd_own", 3);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wd_hold", 32'(arb.grant_valid), 1);
            check("wd_quiet", 32'(arb.timeout), 0);
        end
        tick();
        check("wd_revoke", 32'(arb.grant_valid), 0);
        check("wd_pulse", 32'(arb.timeout), 1);
        check("wd_busy", 32'(arb.bus_busy), 1);
        tick();
        check("wd_pulse_end", 32'(arb.timeout), 0);
        tick();
        check("wd_gap", 32'(arb.grant_valid), 0);
        tick();
        owned("wd_next", 4);
        drain();

        // enable drop releases without timeout and blocks regrant
        arb.req = 16'h0040;
        tick();
        owned("en_own", 6);
        tick();
        arb.node_en = 16'hFFBF;
        tick();
        check("en_rel", 32'(arb.grant_valid), 0);
        check("en_no_to", 32'(arb.timeout), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("en_blocked", 32'(arb.grant_valid), 0);
            check("en_no_to2", 32'(arb.timeout), 0);
        end
        check("en_idle", 32'(arb.bus_busy), 0);
        arb.req     = '0;
        arb.node_en = 16'hFFFF;
        tick();

        // async reset mid-frame, then ptr restarts at 0
        arb.req = 16'h0002;
        tick();
        owned("rst_own", 1);
        #2 reset_n = 1'b0;
        #1 idle_out("rst_async");
        arb.req = 16'h0003;
        tick();
        tick();
        idle_out("rst_held");
        reset_n = 1'b1;
        tick();
        owned("rst_after", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
